// File: rtl/pixel_lane_buffer.sv
// Packs narrow pixels LANES-wide into ping-pong banks and streams the words out
// through a 2-entry skid, so filling one bank overlaps with draining the other.
module pixel_lane_buffer #(
    parameter int PIX_W      = 8,
    parameter int LANES      = 4,
    parameter int BANK_WORDS = 128,
    parameter int LEN_W      = 18
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic                   msb_first,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*PIX_W-1:0] out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   complete
);
    localparam int WW = LANES * PIX_W;
    localparam int AW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int LW = $clog2(LANES);
    localparam int EW = WW + 3;  // {bank, end-of-bank, last, data}

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, pix_cnt_q;
    logic              msb_q;
    logic [LW-1:0]     lane_q;
    logic [WW-1:0]     pack_q, pack_d;
    logic              wr_bank_q, rd_bank_q;
    logic [AW-1:0]     wr_addr_q, rd_addr_q;
    logic [1:0]        full_q, pend_q, blast_q;
    logic [1:0][AW:0]  bcnt_q;
    logic              rd_vld_q;
    logic [2:0]        rd_meta_q;
    logic [WW-1:0]     rd_data_q;
    logic [EW-1:0]     sk_q [2];
    logic [EW-1:0]     sk_d [2];
    logic [1:0]        sk_cnt_q, sk_cnt_d;
    logic [WW-1:0]     mem [2*BANK_WORDS];

    logic          acc, last_pix, commit, hand;
    logic          rd_go, rd_end, out_hs, pop, push, direct;
    logic [EW-1:0] rd_ent, head;

    // full_q: bank owned by the reader until its last word is handshaked.
    // pend_q: bank still has words the reader has not yet issued.
    assign in_ready = (state_q == RUN) && !full_q[wr_bank_q] && (pix_cnt_q < len_q);
    assign acc      = in_valid && in_ready;
    assign last_pix = (pix_cnt_q + LEN_W'(1)) == len_q;
    assign commit   = acc && ((lane_q == LW'(LANES - 1)) || last_pix);
    assign hand     = commit && ((wr_addr_q == AW'(BANK_WORDS - 1)) || last_pix);

    always_comb begin
        pack_d = pack_q;
        for (int j = 0; j < LANES; j++)
            if (lane_q == LW'(j))
                pack_d[(msb_q ? (LANES - 1 - j) : j) * PIX_W +: PIX_W] = in_data;
    end

    // Skid head wins over the fresh read word, which is always younger.
    assign rd_ent    = {rd_meta_q, rd_data_q};
    assign head      = (sk_cnt_q != 2'd0) ? sk_q[0] : rd_ent;
    assign out_valid = (sk_cnt_q != 2'd0) || rd_vld_q;
    assign out_data  = out_valid ? head[WW-1:0] : '0;
    assign out_last  = out_valid && head[WW];
    assign out_hs    = out_valid && out_ready;
    assign pop       = out_hs && (sk_cnt_q != 2'd0);
    assign direct    = out_hs && (sk_cnt_q == 2'd0);
    assign push      = rd_vld_q && !direct;

    always_comb begin
        sk_d     = sk_q;
        sk_cnt_d = sk_cnt_q;
        if (pop) begin
            sk_d[0]  = sk_q[1];
            sk_cnt_d = sk_cnt_d - 2'd1;
        end
        if (push) begin
            sk_d[sk_cnt_d[0]] = rd_ent;
            sk_cnt_d          = sk_cnt_d + 2'd1;
        end
    end

    // Issue only if the skid can still absorb this read when it lands.
    assign rd_end = ({1'b0, rd_addr_q} + (AW+1)'(1)) == bcnt_q[rd_bank_q];
    assign rd_go  = (state_q == RUN) && pend_q[rd_bank_q] && (sk_cnt_d != 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (frame_len == '0) ? DONE : RUN;
            RUN:     if (out_hs && head[WW]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN) || (state_q == DONE);
    assign complete = (state_q == DONE);

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            msb_q     <= 1'b0;
            pix_cnt_q <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            full_q    <= '0;
            pend_q    <= '0;
            blast_q   <= '0;
            bcnt_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_meta_q <= '0;
            sk_q[0]   <= '0;
            sk_q[1]   <= '0;
            sk_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            sk_q     <= sk_d;
            sk_cnt_q <= sk_cnt_d;
            rd_vld_q <= rd_go;
            if (state_q == IDLE) begin
                pix_cnt_q <= '0;
                lane_q    <= '0;
                pack_q    <= '0;
                wr_bank_q <= 1'b0;
                wr_addr_q <= '0;
                rd_bank_q <= 1'b0;
                rd_addr_q <= '0;
                full_q    <= '0;
                pend_q    <= '0;
                blast_q   <= '0;
                if (start) begin
                    len_q <= frame_len;
                    msb_q <= msb_first;
                end
            end else begin
                if (acc) begin
                    pix_cnt_q <= pix_cnt_q + LEN_W'(1);
                    lane_q    <= commit ? '0 : lane_q + LW'(1);
                    pack_q    <= commit ? '0 : pack_d;
                end
                if (commit) wr_addr_q <= hand ? '0 : wr_addr_q + AW'(1);
                if (hand) begin
                    full_q[wr_bank_q]  <= 1'b1;
                    pend_q[wr_bank_q]  <= 1'b1;
                    blast_q[wr_bank_q] <= last_pix;
                    bcnt_q[wr_bank_q]  <= {1'b0, wr_addr_q} + (AW+1)'(1);
                    wr_bank_q          <= ~wr_bank_q;
                end
                if (rd_go) begin
                    rd_meta_q <= {rd_bank_q, rd_end, rd_end && blast_q[rd_bank_q]};
                    if (rd_end) begin
                        pend_q[rd_bank_q] <= 1'b0;
                        rd_addr_q         <= '0;
                        rd_bank_q         <= ~rd_bank_q;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                if (out_hs && head[WW+1]) full_q[head[WW+2]] <= 1'b0;
            end
        end
    end

    // Bank storage: plain BRAM, one write port and one registered read port.
    always_ff @(posedge CLK) begin
        if (commit) mem[{wr_bank_q, wr_addr_q}] <= pack_d;
        if (rd_go)  rd_data_q <= mem[{rd_bank_q, rd_addr_q}];
    end
endmodule

// File: tb/tb_pixel_lane_buffer.sv
// Directed bench for pixel_lane_buffer: expected words queued per frame,
// checked against every output handshake, plus timing and reset checks.
module tb_pixel_lane_buffer;
    localparam int PIX_W = 8, LANES = 4, BW = 4, LEN_W = 18;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, msb_first = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [LEN_W-1:0] frame_len = '0;
    logic [PIX_W-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, complete;
    logic [LANES*PIX_W-1:0] out_data;

    pixel_lane_buffer #(.PIX_W(PIX_W), .LANES(LANES), .BANK_WORDS(BW), .LEN_W(LEN_W)) dut (
        .CLK(clk), .rst(rst), .start(start), .frame_len(frame_len), .msb_first(msb_first),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .complete(complete));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [32:0] sb[$];
    int hs_cyc[$], vld_rise[$];
    int comp_cnt = 0, comp_cyc = 0, n_hs = 0;
    int bc, bh, bv, bn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkword(input int base, input int len, input int w, input bit msb);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            int idx;
            idx = w * LANES + j;
            if (idx < len) r[(msb ? LANES - 1 - j : j) * PIX_W +: PIX_W] = 8'(base + idx);
        end
        return r;
    endfunction

    task automatic expect_frame(input int base, input int len, input bit msb);
        int nw;
        nw = (len + LANES - 1) / LANES;
        sb.delete();
        for (int w = 0; w < nw; w++) sb.push_back({w == nw - 1, mkword(base, len, w, msb)});
    endtask

    task automatic snap();
        bc = comp_cnt; bh = hs_cyc.size(); bv = vld_rise.size(); bn = n_hs;
    endtask

    task automatic do_start(input int len, input bit msb);
        frame_len = len[LEN_W-1:0];
        msb_first = msb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input int n, input int base, output int first_c, output int last_c, output bit ok);
        ok = 1'b1; first_c = -1; last_c = -1;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            @(negedge clk);
            while (!in_ready && w < 200) begin @(negedge clk); w++; end
            if (!in_ready) begin ok = 1'b0; break; end
            if (i == 0) first_c = cyc;
            last_c = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int nw);
        for (int k = 0; k < 500 && comp_cnt == bc; k++) @(negedge clk);
        chk({tag, "_done"}, comp_cnt > bc, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_nwords"}, n_hs - bn, nw);
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_complete_once"}, comp_cnt - bc, 1);
        if (nw > 0 && hs_cyc.size() > 0)
            chk({tag, "_complete_cyc"}, comp_cyc, hs_cyc[hs_cyc.size() - 1] + 1);
        @(posedge clk); #1;
    endtask

    // Output monitor: scoreboard pops, skid stability, valid edges, complete pulses.
    initial begin : mon
        logic prev_v;
        bit stall;
        logic [32:0] sw, e;
        prev_v = 1'b0; stall = 1'b0; sw = '0;
        forever begin
            @(negedge clk);
            if (rst && stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_word", {out_last, out_data}, sw);
            end
            stall = rst && out_valid && !out_ready;
            sw = {out_last, out_data};
            if (out_valid && !prev_v) vld_rise.push_back(cyc);
            prev_v = out_valid;
            if (complete) begin comp_cnt++; comp_cyc = cyc; end
            if (out_valid && out_ready) begin
                n_hs++;
                hs_cyc.push_back(cyc);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("word%0d", n_hs), {out_last, out_data}, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l;
        bit ok;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ctl", {in_ready, out_valid, out_last, busy, complete}, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: lsb-first, one full bank
        snap(); expect_frame(0, 16, 0);
        do_start(16, 0);
        drive(16, 0, f, l, ok);
        chk("t1_acc", ok, 1);
        finish_frame("t1", 4);
        chk("t1_first_valid", vld_rise.size() > bv ? vld_rise[bv] : -1, l + 2);
        chk("t1_stream", hs_cyc[bh + 3] - hs_cyc[bh], 3);

        // 2: msb-first
        snap(); expect_frame(0, 16, 1);
        do_start(16, 1);
        drive(16, 0, f, l, ok);
        chk("t2_acc", ok, 1);
        finish_frame("t2", 4);

        // 3: partial final word, input closed after frame_len
        snap(); expect_frame(8'h10, 6, 0);
        do_start(6, 0);
        drive(6, 8'h10, f, l, ok);
        chk("t3_acc", ok, 1);
        in_valid = 1'b1; in_data = 8'h16;
        @(negedge clk);
        chk("t3_ready_closed0", in_ready, 0);
        @(negedge clk);
        chk("t3_ready_closed1", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish_frame("t3", 2);

        // 4: backpressure fills both banks, then drain
        out_ready = 1'b0;
        snap(); expect_frame(8'h40, 64, 0);
        do_start(64, 0);
        drive(32, 8'h40, f, l, ok);
        chk("t4_acc_first32", ok, 1);
        in_valid = 1'b1; in_data = 8'h60;
        repeat (4) @(negedge clk);
        chk("t4_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(32, 8'h60, f, l, ok);
        chk("t4_acc_rest", ok, 1);
        chk("t4_resume_cyc", f, hs_cyc.size() > bh + 3 ? hs_cyc[bh + 3] + 1 : -1);
        finish_frame("t4", 16);
        chk("t4_burst", hs_cyc[bh + 7] - hs_cyc[bh], 7);

        // 5: empty frame
        snap();
        do_start(0, 0);
        @(negedge clk);
        chk("t5_complete", complete, 1);
        chk("t5_busy", busy, 1);
        chk("t5_no_valid", out_valid, 0);
        @(negedge clk);
        chk("t5_complete_end", complete, 0);
        chk("t5_busy_end", busy, 0);
        chk("t5_no_words", n_hs - bn, 0);
        @(posedge clk); #1;

        // 6: reset mid-frame, then a fresh short frame
        snap(); sb.delete();
        do_start(40, 0);
        drive(10, 8'h80, f, l, ok);
        chk("t6_acc", ok, 1);
        @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_ctl", {in_ready, out_valid, out_last, busy, complete}, 0);
        chk("t6_rst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_complete", comp_cnt - bc, 0);
        chk("t6_no_words", n_hs - bn, 0);
        snap(); expect_frame(0, 4, 0);
        do_start(4, 0);
        drive(4, 0, f, l, ok);
        chk("t6_acc_new", ok, 1);
        finish_frame("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
